// File: rtl/exec_alu_datapath_pkg.sv
// Shared constants for the execute-stage datapath: word size, ALU opcodes
// and the multiply latency that the hazard unit's stall counter also uses.
package exec_alu_datapath_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int MUL_LATENCY = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/exec_alu_datapath_mul_pipe.sv
// Fixed-latency multiplier: low WIDTH bits of a*b captured every cycle and
// shifted through STAGES registers with no valid/flush tracking.
module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    // Only the low word is kept, so signed and unsigned products coincide.
    always_comb begin
        stage_d[0] = a * b;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign p = stage_q[STAGES-1];

endmodule

// File: rtl/exec_alu_datapath.sv
// Execute-stage datapath: operand-B mux, ALU with zero flag, branch-target
// adder. Only the MUL opcode is registered, via mul_pipe.
module exec_alu_datapath
    import exec_alu_datapath_pkg::*;
#(
    parameter int WIDTH      = WORD_SIZE,
    parameter int MUL_STAGES = MUL_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] write_data,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] pc,
    input  logic             alu_src,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_target,
    output logic [WIDTH-1:0] src_b
);

    logic [WIDTH-1:0] mul_p;

    assign src_b     = alu_src ? imm_ext : write_data;
    assign pc_target = pc + imm_ext;

    mul_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk (clk),
        .rst (rst),
        .a   (src_a),
        .b   (src_b),
        .p   (mul_p)
    );

    // MUL output is stale until the stall has covered MUL_STAGES edges.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_MUL:  alu_result = mul_p;
            ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: tb/tb_exec_alu_datapath.sv
// Directed bench for exec_alu_datapath: combinational ops, branch target,
// multiply latency, back-to-back multiplies and asynchronous reset.
module tb_exec_alu_datapath;
    import exec_alu_datapath_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] src_a;
    logic [W-1:0] write_data;
    logic [W-1:0] imm_ext;
    logic [W-1:0] pc;
    logic         alu_src;
    logic [2:0]   alu_control;
    logic [W-1:0] alu_result;
    logic         zero;
    logic [W-1:0] pc_target;
    logic [W-1:0] src_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_alu_datapath #(
        .WIDTH      (W),
        .MUL_STAGES (MUL_LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_a       (src_a),
        .write_data  (write_data),
        .imm_ext     (imm_ext),
        .pc          (pc),
        .alu_src     (alu_src),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero        (zero),
        .pc_target   (pc_target),
        .src_b       (src_b)
    );

    task automatic check_output(input string tag, input logic [W-1:0] observed,
                                input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] wd,
                                  input logic [W-1:0] imm, input logic sel,
                                  input logic [2:0] op);
        src_a       = a;
        write_data  = wd;
        imm_ext     = imm;
        alu_src     = sel;
        alu_control = op;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pc  = '0;
        apply_stimulus(32'h0, 32'h0, 32'h0, 1'b0, ALU_MUL);
        check_output("reset_mul_result", alu_result, 32'h0);
        check_output("reset_mul_zero", {31'b0, zero}, 32'h1);
        apply_stimulus(32'h3, 32'h4, 32'h0, 1'b0, ALU_ADD);
        check_output("reset_add_comb", alu_result, 32'h7);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_ADD);
        check_output("add_wrap", alu_result, 32'h0);
        check_output("add_wrap_zero", {31'b0, zero}, 32'h1);
        apply_stimulus(32'h5, 32'h7, 32'h0, 1'b0, ALU_SUB);
        check_output("sub_neg", alu_result, 32'hFFFF_FFFE);
        check_output("sub_neg_zero", {31'b0, zero}, 32'h0);
        apply_stimulus(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, ALU_SUB);
        check_output("beq_equal_zero", {31'b0, zero}, 32'h1);

        apply_stimulus(32'h0F0F_0F0F, 32'hAAAA_0000, 32'h0000_FFFF, 1'b1, ALU_AND);
        check_output("and_imm", alu_result, 32'h0000_0F0F);
        check_output("src_b_imm", src_b, 32'h0000_FFFF);
        apply_stimulus(32'h0F0F_0F0F, 32'hAAAA_0000, 32'h0000_FFFF, 1'b1, ALU_OR);
        check_output("or_imm", alu_result, 32'h0F0F_FFFF);
        apply_stimulus(32'h0F0F_0F0F, 32'hAAAA_0000, 32'h0000_FFFF, 1'b1, ALU_XOR);
        check_output("xor_imm", alu_result, 32'h0F0F_F0F0);
        apply_stimulus(32'h0F0F_0F0F, 32'hAAAA_0000, 32'h0000_FFFF, 1'b0, ALU_XOR);
        check_output("src_b_reg", src_b, 32'hAAAA_0000);

        apply_stimulus(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_SLT);
        check_output("slt_neg", alu_result, 32'h1);
        apply_stimulus(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_SLTU);
        check_output("sltu_big", alu_result, 32'h0);
        check_output("sltu_zero", {31'b0, zero}, 32'h1);
        apply_stimulus(32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, ALU_SLTU);
        check_output("sltu_small", alu_result, 32'h1);

        pc = 32'h0000_0010;
        apply_stimulus(32'h0, 32'h0, 32'hFFFF_FFF8, 1'b1, ALU_ADD);
        check_output("pc_target_back", pc_target, 32'h0000_0008);
        pc = 32'hFFFF_FFFC;
        apply_stimulus(32'h0, 32'h0, 32'h0000_0008, 1'b1, ALU_ADD);
        check_output("pc_target_wrap", pc_target, 32'h0000_0004);

        // Clean pipeline, then 6*7 held from the start of the MUL.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(32'd6, 32'd7, 32'h0, 1'b0, ALU_MUL);
        tick(3);
        check_output("mul_early_stale", alu_result, 32'h0);
        tick(1);
        check_output("mul_42", alu_result, 32'd42);
        tick(1);
        check_output("mul_42_hold", alu_result, 32'd42);

        @(negedge clk);
        apply_stimulus(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, ALU_MUL);
        tick(3);
        check_output("mul_big_stale", alu_result, 32'd42);
        tick(1);
        check_output("mul_big_low", alu_result, 32'h0);
        check_output("mul_big_zero", {31'b0, zero}, 32'h1);

        @(negedge clk);
        apply_stimulus(32'd3, 32'h0, 32'd5, 1'b1, ALU_MUL);
        tick(4);
        check_output("mul_b2b_imm", alu_result, 32'd15);

        @(negedge clk);
        apply_stimulus(32'd9, 32'd9, 32'h0, 1'b0, ALU_MUL);
        tick(2);
        check_output("mul_pre_reset", alu_result, 32'd15);
        #2;
        rst = 1'b1;
        #1;
        check_output("mul_async_reset", alu_result, 32'h0);
        check_output("mul_async_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        check_output("mul_after_reset_stale", alu_result, 32'h0);
        tick(1);
        check_output("mul_after_reset", alu_result, 32'd81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_alu_datapath.md
Name: exec_alu_datapath

Overview:
Execute-stage arithmetic datapath of the 5-stage RISC-V-style core. It contains three parts: the operand-B select mux (register vs immediate), the 3-bit-opcode ALU with zero flag, and the branch-target adder (PC + immediate). Everything is combinational except the multiply path, which is a fixed-latency pipeline. The surrounding hazard unit stalls the stage for 4 cycles while a multiply is in EX.

Parameters:
WIDTH, 32, datapath width in bits
MUL_STAGES, 4, register stages in the multiply pipeline (equal to the hazard-unit stall count)

Ports:
clk  input  1  clock; multiply pipeline registers update on the rising edge
rst  input  1  asynchronous, active-high reset
src_a  input  WIDTH  operand A, already forwarded
write_data  input  WIDTH  forwarded rs2 value
imm_ext  input  WIDTH  sign-extended immediate
pc  input  WIDTH  PC of the instruction in EX
alu_src  input  1  0 selects write_data as operand B, 1 selects imm_ext
alu_control  input  3  operation select
alu_result  output  WIDTH  ALU result
zero  output  1  1 when alu_result equals 0
pc_target  output  WIDTH  pc + imm_ext
src_b  output  WIDTH  selected operand B (debug/visibility)

Behaviour:
- Operand B: src_b = alu_src ? imm_ext : write_data. Purely combinational.
- pc_target = pc + imm_ext, modulo 2^WIDTH. Carry is discarded. Combinational.
- alu_control encoding; all results are combinational except 100:
  - 000 ADD: a+b, wrap-around, no overflow flag.
  - 001 SUB: a-b, two's complement wrap.
  - 010 AND.
  - 011 OR.
  - 100 MUL: low WIDTH bits of a*b, unsigned/signed-agnostic; result from the pipeline.
  - 101 SLT: 1 if $signed(a) < $signed(b), else 0; zero-extended.
  - 110 XOR.
  - 111 SLTU: 1 if a < b unsigned, else 0.
- zero = (alu_result == 0) for every opcode. BEQ uses SUB, so equal operands give zero=1.
- MUL pipeline:
  - Stage 1 registers a*b low WIDTH bits every cycle, regardless of opcode.
  - Stages 2..MUL_STAGES shift the value along every cycle.
  - alu_result for opcode 100 is the last stage output.
  - Contract: operands stay stable for MUL_STAGES cycles (stage stalled). The result is valid in the cycle after the MUL_STAGES-th rising edge since the operands first appeared.
  - With MUL_STAGES=4, the result is valid in the 5th cycle of the MUL, which is the first non-stalled cycle, when EX/MEM captures it.
  - Before that, alu_result carries stale pipeline contents. This is permitted; the stall masks it.
- Pipeline ignores operand changes mid-sequence. New operands simply restart the fill; there is no flush logic.
- Reset: async rst clears all multiply stages to 0 immediately.
  - During reset with alu_control=100: alu_result=0, zero=1.
  - Combinational outputs (src_b, pc_target, non-MUL results) are unaffected by reset.
- Back-to-back MULs: the second MUL's result is valid MUL_STAGES edges after its operands are applied. Same rule as a single MUL.
- No X propagation from reset: all registers have a defined reset value.

Decomposition:
- Shared package/constants file:
  - WORD_SIZE=32.
  - ALU opcode localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_SLT, ALU_XOR, ALU_SLTU.
  - MUL_LATENCY=4, shared with the hazard unit's stall counter.
- Sub-module: one natural sub-module, mul_pipe (WIDTH, STAGES, clk, rst, a, b, p).
- Mux and adder are inline continuous assignments inside exec_alu_datapath.

Test Plan:
- ADD/SUB/wrap: a=0xFFFFFFFF, b=1 via alu_src=0, op 000 -> alu_result=0, zero=1. Op 001, a=5, b=7 -> 0xFFFFFFFE, zero=0.
- Immediate select + logic: write_data=0xAAAA0000, imm_ext=0x0000FFFF, alu_src=1, a=0x0F0F0F0F:
  - op 010 -> 0x00000F0F.
  - op 011 -> 0x0F0FFFFF.
  - op 110 -> 0x0F0FF0F0.
  - src_b=0x0000FFFF.
- Compare: a=0xFFFFFFFF, b=1:
  - op 101 -> 1.
  - op 111 -> 0, zero=1.
- Branch target: pc=0x00000010, imm_ext=0xFFFFFFF8 -> pc_target=0x00000008. pc=0xFFFFFFFC, imm=8 -> 0x00000004.
- MUL latency: hold a=6, b=7, op 100 from cycle 0:
  - alu_result=42 from cycle 4 onward (after the 4th edge), not earlier with fresh operands.
  - a=0x10000, b=0x10000 -> low word 0, zero=1.
- Reset mid-MUL: assert rst asynchronously in cycle 2 of a MUL -> alu_result=0 immediately. After release, holding operands for 4 edges -> correct product.
